// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: pipeline freeze / flush / stall sequencing for the 5-stage MIPS core.
// Inputs: clk, rst (async, active-low), forward_en, ID_src1/ID_src2/ID_two_src (ID operands),
//   EXE_dest/EXE_WB_en/EXE_MEM_read, MEM_dest/MEM_WB_en, branch_taken, mem_req/mem_ready.
// Outputs: freeze_all (hold everything), freeze_front (hold PC, IF/ID), bubble (NOP into ID/EXE),
//   flush (clear IF/ID, ID/EXE), ctrl_state (0=RUN 1=MEM_WAIT 2=FLUSH).
// Optional macro HAZARD_STATS_EN adds saturating counters stall_cnt, flush_cnt_total, memwait_cnt.
module hazard_stall_controller #(
  parameter int FLUSH_CYCLES = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       forward_en,
  input  logic [4:0] ID_src1,
  input  logic [4:0] ID_src2,
  input  logic       ID_two_src,
  input  logic [4:0] EXE_dest,
  input  logic       EXE_WB_en,
  input  logic       EXE_MEM_read,
  input  logic [4:0] MEM_dest,
  input  logic       MEM_WB_en,
  input  logic       branch_taken,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       freeze_all,
  output logic       freeze_front,
  output logic       bubble,
  output logic       flush,
  output logic [1:0] ctrl_state
`ifdef HAZARD_STATS_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic [STALL_CNT_W-1:0] flush_cnt_total,
  output logic [STALL_CNT_W-1:0] memwait_cnt
`endif
);
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, FLUSH = 2'd2} state_t;
  localparam logic [2:0] RELOAD = 3'(FLUSH_CYCLES - 1);
  state_t state;
  logic [2:0] flush_cnt;
  logic exe_hit, mem_hit, hazard;
  function automatic logic hit(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2, input logic two);
    return d != 5'd0 && (d == s1 || (two && d == s2));
  endfunction
  // FLUSH forces flush whenever not frozen, which is what suppresses the hazard there.
  always_comb begin
    exe_hit = hit(EXE_dest, ID_src1, ID_src2, ID_two_src);
    mem_hit = hit(MEM_dest, ID_src1, ID_src2, ID_two_src);
    hazard = forward_en ? EXE_MEM_read && exe_hit : (EXE_WB_en && exe_hit) || (MEM_WB_en && mem_hit);
    freeze_all = mem_req && !mem_ready;
    flush = !freeze_all && (branch_taken || state == FLUSH);
    freeze_front = !freeze_all && !flush && hazard;
    bubble = freeze_front;
    ctrl_state = state;
  end
  // A memory wait inside FLUSH just holds the count rather than leaving for MEM_WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      flush_cnt <= '0;
    end else if (freeze_all) begin
      state <= state == FLUSH ? FLUSH : MEM_WAIT;
    end else if (branch_taken) begin
      state <= FLUSH_CYCLES > 1 ? FLUSH : RUN;
      flush_cnt <= RELOAD;
    end else if (state == FLUSH) begin
      flush_cnt <= flush_cnt - 3'd1;
      state <= flush_cnt == 3'd1 ? RUN : FLUSH;
    end else begin
      state <= RUN;
    end
  end
`ifdef HAZARD_STATS_EN
  localparam logic [STALL_CNT_W-1:0] SAT = '1;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt_total <= '0;
      memwait_cnt <= '0;
    end else begin
      if (freeze_front && stall_cnt != SAT) stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      if (flush && flush_cnt_total != SAT) flush_cnt_total <= flush_cnt_total + STALL_CNT_W'(1);
      if (freeze_all && memwait_cnt != SAT) memwait_cnt <= memwait_cnt + STALL_CNT_W'(1);
    end
  end
`else
  logic [STALL_CNT_W-1:0] unused_stats;
  assign unused_stats = '0;
`endif
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: directed and randomized checks of hazard_stall_controller against a reference model.
module tb_hazard_stall_controller;
  localparam int FC = 3;
  localparam int SW = 2;
  localparam int SMAX = (1 << SW) - 1;
  logic clk, rst, forward_en, ID_two_src, EXE_WB_en, EXE_MEM_read, MEM_WB_en, branch_taken, mem_req, mem_ready;
  logic [4:0] ID_src1, ID_src2, EXE_dest, MEM_dest;
  logic freeze_all, freeze_front, bubble, flush;
  logic [1:0] ctrl_state;
`ifdef HAZARD_STATS_EN
  logic [SW-1:0] stall_cnt, flush_cnt_total, memwait_cnt;
`endif
  int checks = 0;
  int errors = 0;
  int m_rem;
  bit m_wait;
  int s_st, s_fl, s_mw;
  logic [5:0] exp_v;
  localparam logic [2:0] FSTIM [15] = '{3'b101, 3'b001, 3'b001, 3'b001, 3'b100, 3'b010, 3'b010, 3'b000,
                                        3'b000, 3'b000, 3'b100, 3'b100, 3'b000, 3'b000, 3'b000};
  localparam logic [5:0] FEXP [15] = '{6'b000100, 6'b000110, 6'b000110, 6'b011000, 6'b000100, 6'b100010,
                                       6'b100010, 6'b000110, 6'b000110, 6'b000000, 6'b000100, 6'b000110,
                                       6'b000110, 6'b000110, 6'b000000};
  hazard_stall_controller #(.FLUSH_CYCLES(FC), .STALL_CNT_W(SW)) dut (
    .clk(clk), .rst(rst), .forward_en(forward_en), .ID_src1(ID_src1), .ID_src2(ID_src2),
    .ID_two_src(ID_two_src), .EXE_dest(EXE_dest), .EXE_WB_en(EXE_WB_en), .EXE_MEM_read(EXE_MEM_read),
    .MEM_dest(MEM_dest), .MEM_WB_en(MEM_WB_en), .branch_taken(branch_taken), .mem_req(mem_req),
    .mem_ready(mem_ready), .freeze_all(freeze_all), .freeze_front(freeze_front), .bubble(bubble),
    .flush(flush), .ctrl_state(ctrl_state)
`ifdef HAZARD_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt_total(flush_cnt_total), .memwait_cnt(memwait_cnt)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [5:0] got();
    return {freeze_all, freeze_front, bubble, flush, ctrl_state};
  endfunction
  // Reference: remaining flush cycles as a plain integer, plus a "waiting on memory" flag.
  function automatic logic [5:0] model_out();
    logic fa, fl, ff, hz;
    bit e1, e2, m1, m2;
    logic [1:0] st;
    e1 = EXE_dest != 0 && EXE_dest == ID_src1;
    e2 = EXE_dest != 0 && ID_two_src && EXE_dest == ID_src2;
    m1 = MEM_dest != 0 && MEM_dest == ID_src1;
    m2 = MEM_dest != 0 && ID_two_src && MEM_dest == ID_src2;
    if (forward_en) hz = EXE_MEM_read && (e1 || e2);
    else hz = (EXE_WB_en && (e1 || e2)) || (MEM_WB_en && (m1 || m2));
    fa = mem_req && !mem_ready;
    fl = !fa && (branch_taken || m_rem > 0);
    ff = !fa && !fl && hz;
    st = m_rem > 0 ? 2'd2 : (m_wait ? 2'd1 : 2'd0);
    return {fa, ff, ff, fl, st};
  endfunction
  task automatic model_adv(input logic [5:0] e);
    if (e[5]) begin
      if (m_rem == 0) m_wait = 1;
    end else begin
      m_wait = 0;
      if (branch_taken) m_rem = FC - 1;
      else if (m_rem > 0) m_rem = m_rem - 1;
    end
    if (e[4] && s_st < SMAX) s_st++;
    if (e[2] && s_fl < SMAX) s_fl++;
    if (e[5] && s_mw < SMAX) s_mw++;
  endtask
  task automatic idle();
    forward_en = 0; ID_src1 = 0; ID_src2 = 0; ID_two_src = 0; EXE_dest = 0; EXE_WB_en = 0;
    EXE_MEM_read = 0; MEM_dest = 0; MEM_WB_en = 0; branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask
  task automatic load_use();
    forward_en = 1; EXE_MEM_read = 1; EXE_WB_en = 1; EXE_dest = 5; ID_src1 = 5;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    idle();
    @(negedge clk);
    rst = 1;
    m_rem = 0; m_wait = 0; s_st = 0; s_fl = 0; s_mw = 0;
  endtask
  task automatic test_reset();
    rst = 0;
    idle();
    #2;
    checks++;
    if (got() !== 6'b0) begin errors++; $display("FAIL reset_during: got %b expected %b", got(), 6'b0); end
    @(negedge clk);
    rst = 1;
    #2;
    checks++;
    if (got() !== 6'b0) begin errors++; $display("FAIL reset_after: got %b expected %b", got(), 6'b0); end
  endtask
  task automatic test_load_use();
    do_reset();
    load_use();
    #2;
    checks++;
    if (got() !== 6'b011000) begin errors++; $display("FAIL load_use_stall: got %b expected %b", got(), 6'b011000); end
    @(negedge clk);
    idle();
    forward_en = 1; ID_src1 = 5;
    #2;
    checks++;
    if (got() !== 6'b0) begin errors++; $display("FAIL load_use_release: got %b expected %b", got(), 6'b0); end
    @(negedge clk);
    load_use();
    EXE_dest = 0; ID_src1 = 0;
    #2;
    checks++;
    if (got() !== 6'b0) begin errors++; $display("FAIL load_use_r0: got %b expected %b", got(), 6'b0); end
    @(negedge clk);
    idle();
    forward_en = 1; EXE_WB_en = 1; EXE_dest = 5; ID_src1 = 5;
    #2;
    checks++;
    if (got() !== 6'b0) begin errors++; $display("FAIL fwd_alu_no_stall: got %b expected %b", got(), 6'b0); end
  endtask
  task automatic test_no_fwd();
    do_reset();
    MEM_WB_en = 1; MEM_dest = 7; ID_two_src = 1; ID_src2 = 7;
    #2;
    checks++;
    if (got() !== 6'b011000) begin errors++; $display("FAIL nofwd_mem_src2: got %b expected %b", got(), 6'b011000); end
    @(negedge clk);
    ID_two_src = 0;
    #2;
    checks++;
    if (got() !== 6'b0) begin errors++; $display("FAIL nofwd_one_src: got %b expected %b", got(), 6'b0); end
    @(negedge clk);
    ID_two_src = 1; forward_en = 1;
    #2;
    checks++;
    if (got() !== 6'b0) begin errors++; $display("FAIL fwd_mem_no_stall: got %b expected %b", got(), 6'b0); end
    @(negedge clk);
    idle();
    EXE_WB_en = 1; EXE_dest = 3; ID_src1 = 3;
    #2;
    checks++;
    if (got() !== 6'b011000) begin errors++; $display("FAIL nofwd_exe_src1: got %b expected %b", got(), 6'b011000); end
  endtask
  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle();
      mem_req = 1; branch_taken = 1;
      #2;
      exp_v = i == 0 ? 6'b100000 : 6'b100001;
      checks++;
      if (got() !== exp_v) begin errors++; $display("FAIL mem_wait_%0d: got %b expected %b", i, got(), exp_v); end
    end
    @(negedge clk);
    mem_ready = 1;
    #2;
    checks++;
    if (got() !== 6'b000101) begin errors++; $display("FAIL mem_ready_branch: got %b expected %b", got(), 6'b000101); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle();
      #2;
      exp_v = i < 2 ? 6'b000110 : 6'b000000;
      checks++;
      if (got() !== exp_v) begin errors++; $display("FAIL mem_then_flush_%0d: got %b expected %b", i, got(), exp_v); end
    end
  endtask
  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      idle();
      branch_taken = FSTIM[i][2];
      mem_req = FSTIM[i][1];
      if (FSTIM[i][0]) load_use();
      #2;
      checks++;
      if (got() !== FEXP[i]) begin errors++; $display("FAIL flush_seq_%0d: got %b expected %b", i, got(), FEXP[i]); end
    end
  endtask
  task automatic test_async_reset();
    do_reset();
    branch_taken = 1;
    @(negedge clk);
    branch_taken = 0;
    #2;
    checks++;
    if (got() !== 6'b000110) begin errors++; $display("FAIL async_pre: got %b expected %b", got(), 6'b000110); end
    #1 rst = 0;
    #1;
    checks++;
    if (got() !== 6'b0) begin errors++; $display("FAIL async_assert: got %b expected %b", got(), 6'b0); end
    @(negedge clk);
    rst = 1;
    #2;
    checks++;
    if (got() !== 6'b0) begin errors++; $display("FAIL async_release: got %b expected %b", got(), 6'b0); end
    @(negedge clk);
    load_use();
    #2;
    checks++;
    if (got() !== 6'b011000) begin errors++; $display("FAIL async_after_stall: got %b expected %b", got(), 6'b011000); end
  endtask
  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      forward_en = 1'($urandom_range(0, 1));
      ID_src1 = 5'($urandom_range(0, 3));
      ID_src2 = 5'($urandom_range(0, 3));
      ID_two_src = 1'($urandom_range(0, 1));
      EXE_dest = 5'($urandom_range(0, 3));
      EXE_WB_en = 1'($urandom_range(0, 1));
      EXE_MEM_read = 1'($urandom_range(0, 1));
      MEM_dest = 5'($urandom_range(0, 3));
      MEM_WB_en = 1'($urandom_range(0, 1));
      branch_taken = $urandom_range(0, 5) == 0;
      mem_req = $urandom_range(0, 2) == 0;
      mem_ready = 1'($urandom_range(0, 1));
      #2;
      exp_v = model_out();
      checks++;
      if (got() !== exp_v) begin errors++; $display("FAIL random_%0d: got %b expected %b", i, got(), exp_v); end
      model_adv(exp_v);
    end
`ifdef HAZARD_STATS_EN
    @(negedge clk);
    checks++;
    if ({stall_cnt, flush_cnt_total, memwait_cnt} !== {SW'(s_st), SW'(s_fl), SW'(s_mw)}) begin
      errors++;
      $display("FAIL random_stats: got %0d/%0d/%0d expected %0d/%0d/%0d", stall_cnt, flush_cnt_total, memwait_cnt, s_st, s_fl, s_mw);
    end
`endif
  endtask
`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    do_reset();
    EXE_WB_en = 1; EXE_dest = 5; ID_src1 = 5;
    repeat (5) @(negedge clk);
    idle();
    #2;
    checks++;
    if ({stall_cnt, flush_cnt_total, memwait_cnt} !== {2'd3, 2'd0, 2'd0}) begin
      errors++;
      $display("FAIL stats_saturate: got %0d/%0d/%0d expected 3/0/0", stall_cnt, flush_cnt_total, memwait_cnt);
    end
    rst = 0;
    #1;
    checks++;
    if (stall_cnt !== 2'd0) begin errors++; $display("FAIL stats_reset: got %0d expected 0", stall_cnt); end
    @(negedge clk);
    rst = 1;
  endtask
`endif
  initial begin
    clk = 0;
    test_reset();
    test_load_use();
    test_no_fwd();
    test_mem_wait();
    test_flush();
    test_async_reset();
    test_random();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
